dbg_ocimem_ctrl: RTL and testbench

- System-clock-domain consumer of the debug slave's decoded JTAG actions (jdo plus the take_action_ocimem_* strobes).
- Executes debugger word reads and writes to the on-chip debug memory through a simple waitrequest master, with address auto-increment and a timeout.
- Returns MonDReg, monitor_ready and monitor_error, which feed back into the debug slave for scan-out.

---
 rtl/dbg_oci_pkg.sv | 16 +
 rtl/dbg_ocimem_timeout.sv | 29 ++
 rtl/dbg_ocimem_ctrl.sv | 115 +++++++++++
 tb/tb_dbg_ocimem_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_oci_pkg.sv
// Shared types and JTAG data-register field positions for the OCI debug-memory
// controller slice.
package dbg_oci_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR
    } oci_state_e;

    localparam int unsigned JDO_RD_BIT    = 35;
    localparam int unsigned JDO_ADDR_LSB  = 26;
    localparam int unsigned JDO_WDATA_MSB = 34;
    localparam int unsigned JDO_WDATA_LSB = 3;

endpackage

// File: rtl/dbg_ocimem_timeout.sv
// Stall counter for one debug-memory access: cleared when a command is
// accepted, counts waitrequest cycles, flags the cycle that reaches TIMEOUT.
module dbg_ocimem_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic hit
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] TOP  = CW'(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && count != TOP) begin
            count <= count + CW'(1);
        end
    end

    // hit fires on the stall cycle that would bring the count to TIMEOUT
    assign hit = inc && (count == LAST);

endmodule

// File: rtl/dbg_ocimem_ctrl.sv
// Executes debugger word reads/writes to on-chip debug memory from decoded
// JTAG strobes, with address auto-increment, stall timeout and sticky error.
module dbg_ocimem_ctrl
    import dbg_oci_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);
    oci_state_e        state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [31:0]       mon_nxt, wdata_nxt;
    logic              err_nxt;
    logic              accept;
    logic              any_strobe;
    logic              stall_inc;
    logic              stall_hit;
    logic              unused_jdo;

    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            addr          <= '0;
            MonDReg       <= '0;
            monitor_error <= 1'b0;
            mem_writedata <= '0;
        end else begin
            state         <= state_nxt;
            addr          <= addr_nxt;
            MonDReg       <= mon_nxt;
            monitor_error <= err_nxt;
            mem_writedata <= wdata_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        mon_nxt   = MonDReg;
        err_nxt   = monitor_error;
        wdata_nxt = mem_writedata;
        case (state)
            IDLE: begin
                if (take_action_ocimem_a) begin
                    addr_nxt = jdo[JDO_ADDR_LSB +: ADDR_W];
                    err_nxt  = 1'b0;
                    if (jdo[JDO_RD_BIT]) begin
                        state_nxt = RD;
                    end
                end else if (take_action_ocimem_b) begin
                    wdata_nxt = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
                    state_nxt = WR;
                end else if (take_no_action_ocimem_a) begin
                    state_nxt = RD;
                end
            end
            RD, WR: begin
                // a strobe arriving mid-access is an overrun; the access itself carries on
                if (any_strobe) begin
                    err_nxt = 1'b1;
                end
                if (!mem_waitrequest) begin
                    if (state == RD) begin
                        mon_nxt = mem_readdata;
                    end
                    addr_nxt  = addr + ADDR_W'(1);
                    state_nxt = IDLE;
                end else if (stall_hit) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept    = (state == IDLE) && (state_nxt != IDLE);
    assign stall_inc = (state != IDLE) && mem_waitrequest;

    dbg_ocimem_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk  (clk),
        .reset(reset),
        .clr  (accept),
        .inc  (stall_inc),
        .hit  (stall_hit)
    );

    // Strobes and ready are pure decodes of the state register, which gives the
    // same edge timing as separately registered flags and keeps them exclusive.
    assign mem_read      = (state == RD);
    assign mem_write     = (state == WR);
    assign monitor_ready = (state == IDLE);
    assign mem_address   = addr;

endmodule

// File: tb/tb_dbg_ocimem_ctrl.sv
// Randomized bench for dbg_ocimem_ctrl: a transaction-level model predicts
// address, read data, error and busy time; a stalling slave memory answers the DUT.
module tb_dbg_ocimem_ctrl;
    localparam int unsigned AW    = 8;
    localparam int unsigned TO    = 4;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [37:0]   jdo = '0;
    logic          take_action_ocimem_a = 1'b0;
    logic          take_action_ocimem_b = 1'b0;
    logic          take_no_action_ocimem_a = 1'b0;
    logic [AW-1:0] mem_address;
    logic          mem_read;
    logic          mem_write;
    logic [31:0]   mem_writedata;
    logic [31:0]   mem_readdata = '0;
    logic          mem_waitrequest = 1'b0;
    logic [31:0]   MonDReg;
    logic          monitor_ready;
    logic          monitor_error;

    dbg_ocimem_ctrl #(
        .ADDR_W (AW),
        .TIMEOUT(TO)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .jdo                    (jdo),
        .take_action_ocimem_a   (take_action_ocimem_a),
        .take_action_ocimem_b   (take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .mem_address            (mem_address),
        .mem_read               (mem_read),
        .mem_write              (mem_write),
        .mem_writedata          (mem_writedata),
        .mem_readdata           (mem_readdata),
        .mem_waitrequest        (mem_waitrequest),
        .MonDReg                (MonDReg),
        .monitor_ready          (monitor_ready),
        .monitor_error          (monitor_error)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned edge_cnt = 0;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [31:0]   exp_mem [DEPTH];
    logic [31:0]   slv_mem [DEPTH];
    logic [AW-1:0] m_addr = '0;
    logic [31:0]   m_mon = '0;
    logic [31:0]   m_wdata = '0;
    logic          m_err = 1'b0;
    int unsigned   m_busy_end = 0;
    int unsigned   exp_rd = 0;
    int unsigned   exp_wr = 0;

    task automatic model_access(input int unsigned e, input logic wr, input int unsigned stall);
        if (stall >= TO) begin
            m_err      = 1'b1;
            m_busy_end = e + TO;
        end else begin
            if (wr) begin
                exp_mem[m_addr] = m_wdata;
                exp_wr++;
            end else begin
                m_mon = exp_mem[m_addr];
                exp_rd++;
            end
            m_addr     = m_addr + 1'b1;
            m_busy_end = e + stall + 1;
        end
    endtask

    task automatic model_step(input int unsigned e, input logic a, input logic b, input logic na,
                              input logic [37:0] j, input int unsigned stall);
        if (!(a || b || na)) return;
        if (e <= m_busy_end) begin
            m_err = 1'b1;
            return;
        end
        if (a) begin
            m_addr = j[26 +: AW];
            m_err  = 1'b0;
            if (j[35]) model_access(e, 1'b0, stall);
        end else if (b) begin
            m_wdata = j[34:3];
            model_access(e, 1'b1, stall);
        end else begin
            model_access(e, 1'b0, stall);
        end
    endtask

    task automatic model_reset(input int unsigned e);
        m_addr     = '0;
        m_mon      = '0;
        m_wdata    = '0;
        m_err      = 1'b0;
        m_busy_end = e;
    endtask

    // ---------------- slave memory with programmable stall ----------------
    int unsigned   next_stall = 0;
    int unsigned   cur_stall = 0;
    int unsigned   cyc = 0;
    int unsigned   last_len = 0;
    int unsigned   rd_acc = 0;
    int unsigned   wr_acc = 0;
    logic          prev_wait = 1'b0;
    logic          prev_rd = 1'b0;
    logic          prev_wr = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [31:0]   prev_wd = '0;

    always @(negedge clk) begin
        if (!reset) check("rw_excl", 32'(mem_read & mem_write), 32'd0);
        if (mem_read || mem_write) begin
            if (cyc == 0) begin
                cur_stall = next_stall;
            end else if (prev_wait) begin
                check("stable_addr", 32'(mem_address), 32'(prev_addr));
                check("stable_wdata", mem_writedata, prev_wd);
                check("stable_req", 32'({mem_read, mem_write}), 32'({prev_rd, prev_wr}));
            end
            mem_waitrequest = (cyc < cur_stall);
            mem_readdata    = $urandom;
            if (!mem_waitrequest) begin
                if (mem_read) begin
                    mem_readdata = slv_mem[mem_address];
                    rd_acc++;
                end else begin
                    slv_mem[mem_address] = mem_writedata;
                    wr_acc++;
                end
            end
            prev_wait = mem_waitrequest;
            prev_rd   = mem_read;
            prev_wr   = mem_write;
            prev_addr = mem_address;
            prev_wd   = mem_writedata;
            cyc++;
        end else begin
            if (cyc != 0) last_len = cyc;
            cyc             = 0;
            prev_wait       = 1'b0;
            mem_waitrequest = 1'($urandom_range(0, 1));
            mem_readdata    = $urandom;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [37:0] jdo_a(input logic rd, input logic [AW-1:0] a);
        logic [37:0] j;
        j = '0;
        j[35] = rd;
        j[26 +: AW] = a;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic cmd(input logic a, input logic b, input logic na, input logic [37:0] j,
                       input int unsigned stall);
        @(negedge clk);
        next_stall = stall;
        model_step(edge_cnt + 1, a, b, na, j, stall);
        jdo                     = j;
        take_action_ocimem_a    = a;
        take_action_ocimem_b    = b;
        take_no_action_ocimem_a = na;
        @(negedge clk);
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic snapshot(input string tag);
        logic idle;
        idle = (edge_cnt >= m_busy_end);
        check({tag, ":ready"}, 32'(monitor_ready), 32'(idle));
        if (idle) begin
            check({tag, ":mon"}, MonDReg, m_mon);
            check({tag, ":err"}, 32'(monitor_error), 32'(m_err));
            check({tag, ":addr"}, 32'(mem_address), 32'(m_addr));
            check({tag, ":wdata"}, mem_writedata, m_wdata);
            check({tag, ":req"}, 32'({mem_read, mem_write}), 32'd0);
        end
    endtask

    task automatic wait_idle(input string tag);
        int unsigned n;
        n = 0;
        while (edge_cnt < m_busy_end && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, ":idle_wait"}, 32'(edge_cnt >= m_busy_end), 32'd1);
        @(negedge clk);
        snapshot(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int unsigned wr_before;
        int unsigned diffs;
        logic [63:0] r;
        logic [37:0] j;
        logic a, b, na;
        int unsigned stall;

        for (int i = 0; i < int'(DEPTH); i++) begin
            slv_mem[i] = $urandom;
            exp_mem[i] = slv_mem[i];
        end
        slv_mem[16] = 32'hDEADBEEF;
        exp_mem[16] = 32'hDEADBEEF;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset(edge_cnt);
        snapshot("reset");

        // address load with read, minimum latency
        cmd(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 8'h10), 0);
        check("ld_rd:busy", 32'(monitor_ready), 32'd0);
        @(negedge clk);
        check("ld_rd:ready2", 32'(monitor_ready), 32'd1);
        check("ld_rd:data", MonDReg, 32'hDEADBEEF);
        check("ld_rd:addr", 32'(mem_address), 32'h11);
        @(negedge clk);
        check("ld_rd:len", last_len, 1);
        snapshot("ld_rd");

        // streamed write then read across the address wrap
        cmd(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 8'hFF), 0);
        wait_idle("wrap_ld");
        cmd(1'b0, 1'b1, 1'b0, jdo_b(32'h12345678), 0);
        wait_idle("wrap_wr");
        check("wrap_wr:mem", slv_mem[255], 32'h12345678);
        cmd(1'b0, 1'b0, 1'b1, '0, 0);
        wait_idle("wrap_rd");
        check("wrap_rd:addr", 32'(mem_address), 32'h01);

        // three stall cycles
        cmd(1'b0, 1'b0, 1'b1, '0, 3);
        wait_idle("stall");
        check("stall:len", last_len, 4);

        // stuck waitrequest -> timeout, then cleared by address load
        cmd(1'b0, 1'b0, 1'b1, '0, 50);
        wait_idle("tmo");
        check("tmo:len", last_len, TO);
        check("tmo:err", 32'(monitor_error), 32'd1);
        cmd(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 8'h05), 0);
        wait_idle("tmo_clr");

        // overrun: write strobe while read in flight
        wr_before = wr_acc;
        cmd(1'b0, 1'b0, 1'b1, '0, 3);
        cmd(1'b0, 1'b1, 1'b0, jdo_b(32'hCAFEF00D), 0);
        wait_idle("ovr");
        check("ovr:nowrite", wr_acc, wr_before);
        check("ovr:err", 32'(monitor_error), 32'd1);

        // simultaneous a and b: only the address load
        wr_before = wr_acc;
        cmd(1'b1, 1'b1, 1'b0, jdo_a(1'b0, 8'h20), 0);
        wait_idle("prio");
        check("prio:nowrite", wr_acc, wr_before);
        check("prio:addr", 32'(mem_address), 32'h20);

        // reset in the middle of a stalled write
        wr_before = wr_acc;
        cmd(1'b0, 1'b1, 1'b0, jdo_b(32'h0BADF00D), 50);
        check("rstw:busy", 32'(mem_write), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset(edge_cnt);
        check("rstw:write", 32'(mem_write), 32'd0);
        snapshot("rstw");
        @(negedge clk);
        check("rstw:nowrite", wr_acc, wr_before);

        // randomized command stream
        for (int it = 0; it < 400; it++) begin
            r = {$urandom, $urandom};
            j = r[37:0];
            if ($urandom_range(0, 3) == 0) j[26 +: AW] = 8'hFE + 8'($urandom_range(0, 1));
            a  = ($urandom_range(0, 9) < 3);
            b  = ($urandom_range(0, 9) < 4);
            na = ($urandom_range(0, 9) < 4);
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 7) : $urandom_range(0, 2);
            cmd(a, b, na, j, stall);
            snapshot("rnd_n1");
            for (int g = 0; g < int'($urandom_range(0, 5)); g++) begin
                @(negedge clk);
                snapshot("rnd");
            end
        end
        wait_idle("final");

        check("final:reads", rd_acc, exp_rd);
        check("final:writes", wr_acc, exp_wr);
        diffs = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (slv_mem[i] !== exp_mem[i]) diffs++;
        end
        check("final:mem_diffs", diffs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
